// File: rtl/commit_opnds.sv
// ============================================================================
// commit_opnds : writeback stage that serialises two decoded destinations into
//                the architectural register file and checks memory hints.
// Revision 1.0
// ============================================================================
`default_nettype none

module commit_opnds (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  dest0_kind,
  input  logic [1:0]  dest1_kind,
  input  logic [31:0] dest0_sel,
  input  logic [31:0] dest1_sel,
  input  logic [31:0] dest0_val,
  input  logic [31:0] dest1_val,
  input  logic [31:0] dest0_addr,
  input  logic [31:0] dest1_addr,
  input  logic        reg_1byte,
  input  logic        prefix_operand_16bit,
  input  logic        hint1_is_write,
  input  logic        hint2_is_write,
  input  logic [31:0] hint1_address,
  input  logic [31:0] hint2_address,
  input  logic [31:0] hint1_data,
  input  logic [31:0] hint2_data,
  output logic [31:0] eax,
  output logic [31:0] ecx,
  output logic [31:0] edx,
  output logic [31:0] ebx,
  output logic [31:0] esp,
  output logic [31:0] ebp,
  output logic [31:0] esi,
  output logic [31:0] edi,
  output logic        commit_done,
  output logic        err_mem_mismatch,
  output logic        err_hint_unused,
  output logic        err_bad_kind
);

  // Destination kind encodings shared with the decode stage.
  localparam logic [1:0] OPND_DEST_NONE     = 2'b00;
  localparam logic [1:0] OPND_DEST_REG_1HOT = 2'b01;
  localparam logic [1:0] OPND_DEST_MEM_1HOT = 2'b10;
  localparam logic [1:0] OPND_DEST_BAD      = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR0  = 2'd1,
    S_WR1  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Holding registers for the accepted request.
  logic [1:0]  r_kind0, r_kind1;
  logic [2:0]  r_sel0, r_sel1;
  logic [31:0] r_val0, r_val1;
  logic [31:0] r_addr0, r_addr1;
  logic        r_b8, r_b16;
  logic        r_h1_wr, r_h2_wr;
  logic [31:0] r_h1_addr, r_h2_addr;
  logic [31:0] r_h1_data, r_h2_data;
  logic        r_h1_used, r_h2_used;

  logic [31:0] r_regs [8];
  logic        r_commit_done;
  logic        r_err_mm, r_err_hu, r_err_bk;

  logic        w_accept;
  logic        w_applying;
  logic [1:0]  w_cur_kind;
  logic [2:0]  w_cur_sel;
  logic [31:0] w_cur_val;
  logic [31:0] w_cur_addr;
  logic [31:0] w_mask;
  logic        w_h1_hit, w_h2_hit;
  logic        w_is_reg, w_is_mem, w_is_bad;
  logic        w_take1, w_take2, w_miss;
  logic [2:0]  w_reg_idx;
  logic [31:0] w_reg_old;
  logic [31:0] w_reg_new;
  logic        w_hint_left;
  logic        w_unused_sel;

  assign w_unused_sel = ^{dest0_sel[31:3], dest1_sel[31:3]};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_WR0;
      S_WR0:   w_next = S_WR1;
      S_WR1:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_ready & in_valid;

  // --------------------------------------------------------------------------
  // Request capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind0   <= dest0_kind;
      r_kind1   <= dest1_kind;
      r_sel0    <= dest0_sel[2:0];
      r_sel1    <= dest1_sel[2:0];
      r_val0    <= dest0_val;
      r_val1    <= dest1_val;
      r_addr0   <= dest0_addr;
      r_addr1   <= dest1_addr;
      r_b8      <= reg_1byte;
      r_b16     <= prefix_operand_16bit;
      r_h1_wr   <= hint1_is_write;
      r_h2_wr   <= hint2_is_write;
      r_h1_addr <= hint1_address;
      r_h2_addr <= hint2_address;
      r_h1_data <= hint1_data;
      r_h2_data <= hint2_data;
    end
  end

  // --------------------------------------------------------------------------
  // Destination being applied this cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_applying = (r_state == S_WR0) || (r_state == S_WR1);
    w_cur_kind = OPND_DEST_NONE;
    w_cur_sel  = 3'd0;
    w_cur_val  = 32'd0;
    w_cur_addr = 32'd0;
    if (r_state == S_WR0) begin
      w_cur_kind = r_kind0;
      w_cur_sel  = r_sel0;
      w_cur_val  = r_val0;
      w_cur_addr = r_addr0;
    end else if (r_state == S_WR1) begin
      w_cur_kind = r_kind1;
      w_cur_sel  = r_sel1;
      w_cur_val  = r_val1;
      w_cur_addr = r_addr1;
    end
  end

  always_comb begin
    if (r_b8) begin
      w_mask = 32'h0000_00FF;
    end else if (r_b16) begin
      w_mask = 32'h0000_FFFF;
    end else begin
      w_mask = 32'hFFFF_FFFF;
    end
  end

  assign w_is_reg = w_applying && (w_cur_kind == OPND_DEST_REG_1HOT);
  assign w_is_mem = w_applying && (w_cur_kind == OPND_DEST_MEM_1HOT);
  assign w_is_bad = w_applying && (w_cur_kind == OPND_DEST_BAD);

  assign w_h1_hit = r_h1_wr && !r_h1_used && (r_h1_addr == w_cur_addr) &&
                    (((r_h1_data ^ w_cur_val) & w_mask) == 32'd0);
  assign w_h2_hit = r_h2_wr && !r_h2_used && (r_h2_addr == w_cur_addr) &&
                    (((r_h2_data ^ w_cur_val) & w_mask) == 32'd0);

  // The first hint wins when both could satisfy the same destination.
  assign w_take1 = w_is_mem && w_h1_hit;
  assign w_take2 = w_is_mem && !w_h1_hit && w_h2_hit;
  assign w_miss  = w_is_mem && !w_h1_hit && !w_h2_hit;

  // Byte selectors 4-7 alias the high byte of eax..ebx rather than esp..edi.
  assign w_reg_idx = r_b8 ? {1'b0, w_cur_sel[1:0]} : w_cur_sel;
  assign w_reg_old = r_regs[w_reg_idx];

  always_comb begin
    if (r_b8) begin
      if (w_cur_sel[2]) begin
        w_reg_new = {w_reg_old[31:16], w_cur_val[7:0], w_reg_old[7:0]};
      end else begin
        w_reg_new = {w_reg_old[31:8], w_cur_val[7:0]};
      end
    end else if (r_b16) begin
      w_reg_new = {w_reg_old[31:16], w_cur_val[15:0]};
    end else begin
      w_reg_new = w_cur_val;
    end
  end

  assign w_hint_left = (r_h1_wr && !r_h1_used) || (r_h2_wr && !r_h2_used);

  // --------------------------------------------------------------------------
  // Architectural register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_is_reg) begin
      r_regs[w_reg_idx] <= w_reg_new;
    end
  end

  // --------------------------------------------------------------------------
  // Hint tracking, completion pulse and sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h1_used     <= 1'b0;
      r_h2_used     <= 1'b0;
      r_commit_done <= 1'b0;
      r_err_mm      <= 1'b0;
      r_err_hu      <= 1'b0;
      r_err_bk      <= 1'b0;
    end else begin
      r_commit_done <= (r_state == S_DONE);
      if (w_accept) begin
        r_h1_used <= 1'b0;
        r_h2_used <= 1'b0;
      end
      if (w_take1) r_h1_used <= 1'b1;
      if (w_take2) r_h2_used <= 1'b1;
      if (w_miss) r_err_mm <= 1'b1;
      if (w_is_bad) r_err_bk <= 1'b1;
      if ((r_state == S_DONE) && w_hint_left) r_err_hu <= 1'b1;
    end
  end

  assign eax = r_regs[0];
  assign ecx = r_regs[1];
  assign edx = r_regs[2];
  assign ebx = r_regs[3];
  assign esp = r_regs[4];
  assign ebp = r_regs[5];
  assign esi = r_regs[6];
  assign edi = r_regs[7];

  assign commit_done      = r_commit_done;
  assign err_mem_mismatch = r_err_mm;
  assign err_hint_unused  = r_err_hu;
  assign err_bad_kind     = r_err_bk;

endmodule

`default_nettype wire

// File: tb/tb_commit_opnds.sv
// ============================================================================
// tb_commit_opnds : directed bench with a reference model and result queue.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_commit_opnds;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  d0k, d1k;
  logic [31:0] d0s, d1s, d0v, d1v, d0a, d1a;
  logic        b8, b16;
  logic        h1w, h2w;
  logic [31:0] h1a, h2a, h1d, h2d;
  logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;
  logic        commit_done, err_mem_mismatch, err_hint_unused, err_bad_kind;

  always #5 clk = ~clk;

  commit_opnds dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dest0_kind(d0k), .dest1_kind(d1k), .dest0_sel(d0s), .dest1_sel(d1s),
    .dest0_val(d0v), .dest1_val(d1v), .dest0_addr(d0a), .dest1_addr(d1a),
    .reg_1byte(b8), .prefix_operand_16bit(b16),
    .hint1_is_write(h1w), .hint2_is_write(h2w),
    .hint1_address(h1a), .hint2_address(h2a),
    .hint1_data(h1d), .hint2_data(h2d),
    .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx),
    .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
    .commit_done(commit_done), .err_mem_mismatch(err_mem_mismatch),
    .err_hint_unused(err_hint_unused), .err_bad_kind(err_bad_kind)
  );

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_REG  = 2'b01;
  localparam logic [1:0] K_MEM  = 2'b10;
  localparam logic [1:0] K_BAD  = 2'b11;

  typedef struct packed {
    logic [7:0][31:0] regs;
    logic             mm;
    logic             hu;
    logic             bk;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_checks = 0;
  int          ncyc = 0;
  logic [31:0] m_regs [8];
  logic        m_mm, m_hu, m_bk, m_u1, m_u2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    case (i)
      0: return eax;
      1: return ecx;
      2: return edx;
      3: return ebx;
      4: return esp;
      5: return ebp;
      6: return esi;
      default: return edi;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_mm = 1'b0; m_hu = 1'b0; m_bk = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] k, input logic [31:0] s,
                             input logic [31:0] v, input logic [31:0] a);
    logic [31:0] mask;
    logic [1:0]  lo;
    mask = b8 ? 32'hFF : (b16 ? 32'hFFFF : 32'hFFFF_FFFF);
    lo   = s[1:0];
    case (k)
      K_REG: begin
        if (b8) begin
          if (s[2]) m_regs[lo][15:8] = v[7:0];
          else      m_regs[lo][7:0]  = v[7:0];
        end else if (b16) begin
          m_regs[s[2:0]][15:0] = v[15:0];
        end else begin
          m_regs[s[2:0]] = v;
        end
      end
      K_MEM: begin
        if (h1w && !m_u1 && h1a == a && ((h1d ^ v) & mask) == 0) m_u1 = 1'b1;
        else if (h2w && !m_u2 && h2a == a && ((h2d ^ v) & mask) == 0) m_u2 = 1'b1;
        else m_mm = 1'b1;
      end
      K_BAD:   m_bk = 1'b1;
      default: ;
    endcase
  endtask

  task automatic clear_stim();
    d0k = K_NONE; d1k = K_NONE; d0s = 0; d1s = 0; d0v = 0; d1v = 0; d0a = 0; d1a = 0;
    b8 = 0; b16 = 0; h1w = 0; h2w = 0; h1a = 0; h2a = 0; h1d = 0; h2d = 0;
  endtask

  task automatic step();
    @(negedge clk);
    ncyc++;
  endtask

  // Presents the current stimulus, waits for the accept edge, queues the expectation.
  task automatic issue();
    exp_t e;
    int   w = 0;
    while (!in_ready && w < 10) begin step(); w++; end
    chk("ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ncyc = 0;
    chk("accepted", {31'd0, in_ready}, 32'd0);
    m_u1 = 1'b0; m_u2 = 1'b0;
    model_apply(d0k, d0s, d0v, d0a);
    model_apply(d1k, d1s, d1v, d1a);
    if ((h1w && !m_u1) || (h2w && !m_u2)) m_hu = 1'b1;
    for (int i = 0; i < 8; i++) e.regs[i] = m_regs[i];
    e.mm = m_mm; e.hu = m_hu; e.bk = m_bk;
    q.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    bit   got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (commit_done) got = 1'b1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_latency", ncyc, 32'd3);
    chk("sb_has_entry", {31'd0, q.size() != 0}, 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), dut_reg(i), e.regs[i]);
      chk("err_mem_mismatch", {31'd0, err_mem_mismatch}, {31'd0, e.mm});
      chk("err_hint_unused", {31'd0, err_hint_unused}, {31'd0, e.hu});
      chk("err_bad_kind", {31'd0, err_bad_kind}, {31'd0, e.bk});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0;
    clear_stim();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_done", {31'd0, commit_done}, 32'd0);
    chk("rst_flags", {29'd0, err_mem_mismatch, err_hint_unused, err_bad_kind}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), dut_reg(i), 32'd0);

    // 32-bit write to ebx
    clear_stim(); d0k = K_REG; d0s = 32'hFFFF_FFF3; d0v = 32'hDEAD_BEEF;
    issue();
    step();
    chk("t1_ebx_n1", ebx, 32'hDEAD_BEEF);
    chk("t1_no_early_done", {31'd0, commit_done}, 32'd0);
    collect();
    step();
    chk("t1_done_one_cycle", {31'd0, commit_done}, 32'd0);

    // Partial-width writes
    clear_stim(); d0k = K_REG; d0s = 0; d0v = 32'h1122_3344;
    issue(); collect();
    clear_stim(); d0k = K_REG; d0s = 4; d0v = 32'hFFFF_FFAB; b8 = 1; b16 = 1;
    issue(); collect();
    chk("t2_ah", eax, 32'h1122_AB44);
    chk("t2_esp", esp, 32'h0);
    clear_stim(); d0k = K_REG; d0s = 0; d0v = 32'h5555_BEEF; b16 = 1;
    issue(); collect();
    chk("t2_ax", eax, 32'h1122_BEEF);
    clear_stim(); d0k = K_REG; d0s = 2; d0v = 32'h1FF; d1k = K_REG; d1s = 6; d1v = 32'h12; b8 = 1;
    issue(); collect();
    chk("t2_dl_dh", edx, 32'h0000_12FF);

    // Same-register conflict
    clear_stim(); d0k = K_REG; d0s = 1; d0v = 1; d1k = K_REG; d1s = 1; d1v = 2;
    issue();
    step(); chk("t3_ecx_n1", ecx, 32'h1);
    step(); chk("t3_ecx_n2", ecx, 32'h2);
    collect();

    // Two memory destinations, hints in swapped order
    clear_stim(); d0k = K_MEM; d0a = 32'h1000; d0v = 5; d1k = K_MEM; d1a = 32'h2000; d1v = 7;
    h1w = 1; h1a = 32'h2000; h1d = 7; h2w = 1; h2a = 32'h1000; h2d = 5;
    issue(); collect();
    chk("t4_clean_flags", {29'd0, err_mem_mismatch, err_hint_unused, err_bad_kind}, 32'd0);

    // Byte-width compare ignores upper data bits; non-write hint is not required
    clear_stim(); b8 = 1; d0k = K_MEM; d0a = 32'h40; d0v = 32'h1234_56AB;
    h1w = 1; h1a = 32'h40; h1d = 32'hFFFF_FFAB; h2w = 0; h2a = 32'h40; h2d = 32'hAB;
    d1k = K_REG; d1s = 7; d1v = 32'h9C;
    issue(); collect();

    // Illegal kind
    clear_stim(); d0k = K_BAD; d0s = 3; d0v = 32'h1;
    issue(); collect();
    chk("bk_ebx_kept", ebx, 32'hDEAD_9CEF);

    // Mismatch and unused hint
    clear_stim(); d0k = K_MEM; d0a = 32'h1000; d0v = 5;
    h1w = 1; h1a = 32'h1000; h1d = 6; h2w = 1; h2a = 32'h3000; h2d = 0;
    issue();
    step();
    chk("t5_mm_n1", {31'd0, err_mem_mismatch}, 32'd1);
    chk("t5_hu_n1", {31'd0, err_hint_unused}, 32'd0);
    step();
    chk("t5_hu_n2", {31'd0, err_hint_unused}, 32'd0);
    collect();
    clear_stim(); d0k = K_REG; d0s = 6; d0v = 32'h77;
    issue(); collect();
    chk("t5_sticky", {30'd0, err_mem_mismatch, err_hint_unused}, 32'd3);

    // Continuous in_valid, then reset during WR1 of the second request
    clear_stim(); d0k = K_REG; d0s = 5; d0v = 32'h55; d1k = K_REG; d1s = 4; d1v = 32'h66;
    in_valid = 1'b1;
    step(); chk("hs_busy_n0", {31'd0, in_ready}, 32'd0);
    step(); chk("hs_busy_n1", {31'd0, in_ready}, 32'd0);
    chk("hs_ebp", ebp, 32'h55);
    step(); chk("hs_busy_n2", {31'd0, in_ready}, 32'd0);
    chk("hs_esp", esp, 32'h66);
    step(); chk("hs_ready_n3", {31'd0, in_ready}, 32'd1);
    chk("hs_done_n3", {31'd0, commit_done}, 32'd1);
    step(); chk("hs_reaccept_n4", {31'd0, in_ready}, 32'd0);
    step();
    rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("mid_rst_reg%0d", i), dut_reg(i), 32'd0);
    chk("mid_rst_flags", {29'd0, err_mem_mismatch, err_hint_unused, err_bad_kind}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (6) begin
      step();
      if (commit_done) seen = 1'b1;
    end
    chk("no_done_after_reset", {31'd0, seen}, 32'd0);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    chk("sb_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
